// File: rtl/multdiv_error_logger_pkg.sv
// Shared constants and types for the mult/div residue-error logger:
// opcodes, FSM encodings and the captured-operation snapshot record.
package multdiv_error_logger_pkg;

  localparam logic [4:0] OPC_MULT = 5'b00110;
  localparam logic [4:0] OPC_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOGGED = 2'b01,
    ST_ALERT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] result;
    logic [31:0] rem;
  } snap_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OPC_MULT) || (op == OPC_DIV);
  endfunction

endpackage

// File: rtl/multdiv_error_logger_if.sv
// Completion bus from the mult/div datapath into the error logger.
interface multdiv_error_logger_if;
  import multdiv_error_logger_pkg::*;

  logic        inValid;
  logic [4:0]  inOpcode;
  logic [31:0] inA;
  logic [15:0] inB;
  logic [31:0] inMultDivResult;
  logic [31:0] inRemainder;
  logic        inError;

  modport master (
    output inValid, inOpcode, inA, inB, inMultDivResult, inRemainder, inError
  );

  modport slave (
    input  inValid, inOpcode, inA, inB, inMultDivResult, inRemainder, inError
  );
endinterface

// File: rtl/multdiv_error_logger_sat_counter.sv
// Saturating up-counter. A clear restarts the count; an increment in the
// same cycle counts as the first event of the new run.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = inc ? W'(1) : '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/multdiv_error_logger.sv
// Counts checked mult/div operations and residue errors, snapshots the first
// failing operation and raises a level interrupt once enough errors are pending.
module multdiv_error_logger
  import multdiv_error_logger_pkg::*;
#(
  parameter int COUNT_WIDTH   = 16,
  parameter int ERR_THRESHOLD = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  multdiv_error_logger_if.slave  bus,
  input  logic                   inIrqAck,
  input  logic                   inClear,
  output logic [COUNT_WIDTH-1:0] outOpCount,
  output logic [COUNT_WIDTH-1:0] outErrorCount,
  output logic                   outSnapValid,
  output logic [4:0]             outSnapOpcode,
  output logic [31:0]            outSnapA,
  output logic [15:0]            outSnapB,
  output logic [31:0]            outSnapResult,
  output logic [31:0]            outSnapRemainder,
  output logic                   outIrq,
  output logic [1:0]             outState
);

  localparam logic [COUNT_WIDTH-1:0] THR = COUNT_WIDTH'(ERR_THRESHOLD);

  state_e                 state_q, state_d;
  logic                   snap_valid_q, snap_valid_d;
  snap_t                  snap_q, snap_d, cur_op;
  logic                   op_evt, err_evt, ack;
  logic [COUNT_WIDTH-1:0] pend_cnt, pend_inc;
  logic                   thr_hit;

  assign op_evt  = bus.inValid && is_muldiv(bus.inOpcode);
  assign err_evt = op_evt && bus.inError;
  assign ack     = inIrqAck && (state_q == ST_ALERT);

  assign cur_op = '{opcode: bus.inOpcode, a: bus.inA, b: bus.inB,
                    result: bus.inMultDivResult, rem: bus.inRemainder};

  sat_counter #(.W(COUNT_WIDTH)) u_op_cnt (
    .clock, .reset, .inc(op_evt && !inClear), .clr(inClear), .count_o(outOpCount)
  );

  sat_counter #(.W(COUNT_WIDTH)) u_err_cnt (
    .clock, .reset, .inc(err_evt && !inClear), .clr(inClear), .count_o(outErrorCount)
  );

  // An ack with a coincident error restarts the pending run at 1.
  sat_counter #(.W(COUNT_WIDTH)) u_pend_cnt (
    .clock, .reset, .inc(err_evt && !inClear), .clr(inClear || ack), .count_o(pend_cnt)
  );

  // Pending count as it will stand after this cycle's error is counted.
  assign pend_inc = (pend_cnt == '1) ? pend_cnt : pend_cnt + COUNT_WIDTH'(1);
  assign thr_hit  = (pend_inc >= THR);

  always_comb begin
    state_d      = state_q;
    snap_valid_d = snap_valid_q;
    snap_d       = snap_q;
    case (state_q)
      ST_IDLE: if (err_evt) begin
        snap_d       = cur_op;
        snap_valid_d = 1'b1;
        state_d      = thr_hit ? ST_ALERT : ST_LOGGED;
      end
      ST_LOGGED: if (err_evt && thr_hit) state_d = ST_ALERT;
      ST_ALERT: if (inIrqAck) begin
        state_d      = ST_IDLE;
        snap_valid_d = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        snap_valid_d = 1'b0;
      end
    endcase
    if (inClear) begin
      state_d      = ST_IDLE;
      snap_valid_d = 1'b0;
      snap_d       = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      snap_valid_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
      snap_q       <= snap_d;
    end
  end

  assign outSnapValid     = snap_valid_q;
  assign outSnapOpcode    = snap_q.opcode;
  assign outSnapA         = snap_q.a;
  assign outSnapB         = snap_q.b;
  assign outSnapResult    = snap_q.result;
  assign outSnapRemainder = snap_q.rem;
  assign outIrq           = (state_q == ST_ALERT);
  assign outState         = state_q;

endmodule

// File: tb/tb_multdiv_error_logger.sv
// Three logger configurations share one stimulus stream and are compared
// each cycle against an integer-level reference model.
module tb_multdiv_error_logger;
  import multdiv_error_logger_pkg::*;

  logic clock = 1'b0, reset = 1'b0, irq_ack = 1'b0, clr = 1'b0;
  always #5 clock = ~clock;

  multdiv_error_logger_if mdif();

  logic [2:0][15:0]  o_opc, o_erc;
  logic [2:0][1:0]   o_st;
  logic [2:0]        o_irq, o_sv;
  logic [2:0][116:0] o_snap;

  // k=0: width 16 thr 1; k=1: width 16 thr 3; k=2: width 4 thr 2
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int CW = (k == 2) ? 4 : 16;
    localparam int TH = (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    logic [CW-1:0] opc, erc;
    logic [4:0]    so;
    logic [31:0]   sa, sr, srm;
    logic [15:0]   sb;
    logic          sv, irq;
    logic [1:0]    st;
    multdiv_error_logger #(.COUNT_WIDTH(CW), .ERR_THRESHOLD(TH)) u_dut (
      .clock(clock), .reset(reset), .bus(mdif), .inIrqAck(irq_ack), .inClear(clr),
      .outOpCount(opc), .outErrorCount(erc), .outSnapValid(sv),
      .outSnapOpcode(so), .outSnapA(sa), .outSnapB(sb), .outSnapResult(sr),
      .outSnapRemainder(srm), .outIrq(irq), .outState(st)
    );
    assign o_opc[k]  = 16'(opc);
    assign o_erc[k]  = 16'(erc);
    assign o_st[k]   = st;
    assign o_irq[k]  = irq;
    assign o_sv[k]   = sv;
    assign o_snap[k] = {so, sa, sb, sr, srm};
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integers per configuration
  int           thr[3] = '{1, 3, 2};
  int           mx[3]  = '{65535, 65535, 15};
  int           m_ops[3], m_errs[3], m_pend[3], m_st[3];
  bit           m_sv[3];
  logic [116:0] m_snap[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ops[k] = 0; m_errs[k] = 0; m_pend[k] = 0; m_st[k] = 0;
      m_sv[k] = 1'b0; m_snap[k] = '0;
    end
  endfunction

  function automatic void model_step();
    bit op, err, ackd;
    int newp;
    op  = mdif.inValid && (mdif.inOpcode == 5'd6 || mdif.inOpcode == 5'd7);
    err = op && mdif.inError;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        m_ops[k] = 0; m_errs[k] = 0; m_pend[k] = 0; m_st[k] = 0;
        m_sv[k] = 1'b0; m_snap[k] = '0;
        continue;
      end
      if (op && m_ops[k] < mx[k]) m_ops[k]++;
      if (err && m_errs[k] < mx[k]) m_errs[k]++;
      ackd = irq_ack && m_st[k] == 2;
      if (ackd) newp = err ? 1 : 0;
      else newp = (err && m_pend[k] < mx[k]) ? m_pend[k] + 1 : m_pend[k];
      if (m_st[k] == 0 && err) begin
        m_snap[k] = {mdif.inOpcode, mdif.inA, mdif.inB, mdif.inMultDivResult, mdif.inRemainder};
        m_sv[k]   = 1'b1;
        m_st[k]   = (newp >= thr[k]) ? 2 : 1;
      end else if (m_st[k] == 1 && err && newp >= thr[k]) begin
        m_st[k] = 2;
      end else if (ackd) begin
        m_st[k] = 0;
        m_sv[k] = 1'b0;
      end
      m_pend[k] = newp;
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("opc[%0d]", k), o_opc[k], m_ops[k]);
      chk($sformatf("erc[%0d]", k), o_erc[k], m_errs[k]);
      chk($sformatf("state[%0d]", k), o_st[k], m_st[k]);
      chk($sformatf("irq[%0d]", k), o_irq[k], m_st[k] == 2);
      chk($sformatf("snapvalid[%0d]", k), o_sv[k], m_sv[k]);
      chk($sformatf("snap[%0d]", k), o_snap[k], m_snap[k]);
    end
  endtask

  // Drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic cyc(input bit v, input logic [4:0] op, input logic [31:0] a,
                     input logic [15:0] b, input logic [31:0] r, input logic [31:0] rm,
                     input bit e, input bit ack, input bit c);
    mdif.inValid = v; mdif.inOpcode = op; mdif.inA = a; mdif.inB = b;
    mdif.inMultDivResult = r; mdif.inRemainder = rm; mdif.inError = e;
    irq_ack = ack; clr = c;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    bit          v, e, ak, c;
    logic [4:0]  op;

    mdif.inValid = 0; mdif.inOpcode = 0; mdif.inA = 0; mdif.inB = 0;
    mdif.inMultDivResult = 0; mdif.inRemainder = 0; mdif.inError = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b1;

    // three clean multiplies
    repeat (3) cyc(1, OPC_MULT, 32'd5, 16'd3, 32'd15, 32'd0, 0, 0, 0);
    chk("r038_opc", o_opc[0], 3);
    chk("r038_erc", o_erc[0], 0);
    chk("r038_irq", o_irq[0], 0);
    chk("r038_state", o_st[0], 0);

    // failing divide with threshold 1
    cyc(1, OPC_DIV, 32'd100, 16'd7, 32'd14, 32'd2, 1, 0, 0);
    chk("r039_irq", o_irq[0], 1);
    chk("r039_snapvalid", o_sv[0], 1);
    chk("r039_snap", o_snap[0], {5'd7, 32'd100, 16'd7, 32'd14, 32'd2});

    // threshold 3: LOGGED after first, ALERT after third, snapshot stays first
    cyc(0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, OPC_MULT, 32'd11, 16'd2, 32'd22, 32'd0, 1, 0, 0);
    chk("r040_state1", o_st[1], 2'b01);
    cyc(1, OPC_MULT, 32'd22, 16'd2, 32'd44, 32'd0, 1, 0, 0);
    chk("r040_state2", o_st[1], 2'b01);
    chk("r040_thr2_alert", o_st[2], 2'b10);
    cyc(1, OPC_MULT, 32'd33, 16'd2, 32'd66, 32'd0, 1, 0, 0);
    chk("r040_irq", o_irq[1], 1);
    chk("r040_snapA", o_snap[1][111:80], 32'd11);

    // ack coincident with error, then one more error reaches ALERT at threshold 2
    cyc(1, OPC_DIV, 32'd9, 16'd3, 32'd3, 32'd0, 1, 1, 0);
    chk("r042_erc", o_erc[2], 4);
    chk("r042_state", o_st[2], 2'b00);
    chk("r042_snapvalid", o_sv[2], 0);
    cyc(1, OPC_DIV, 32'd9, 16'd3, 32'd3, 32'd0, 1, 0, 0);
    chk("r042_realert", o_st[2], 2'b10);

    // non mult/div opcode with error is ignored
    cyc(0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5'b00000, 32'd1, 16'd1, 32'd1, 32'd1, 1, 0, 0);
    chk("r041_opc", o_opc[0], 0);
    chk("r041_erc", o_erc[0], 0);
    chk("r041_state", o_st[0], 0);

    // saturation at width 4, then clear beats a coincident error
    repeat (20) cyc(1, OPC_MULT, 32'd2, 16'd2, 32'd4, 32'd0, 0, 0, 0);
    chk("r043_sat", o_opc[2], 15);
    chk("r043_wide", o_opc[0], 20);
    cyc(1, OPC_MULT, 32'd2, 16'd2, 32'd5, 32'd0, 1, 0, 1);
    chk("r043_clr_opc", o_opc[2], 0);
    chk("r043_clr_erc", o_erc[0], 0);
    chk("r043_clr_irq", o_irq, 3'b000);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(99) == 0) begin
        // reset asserted with an erroring op in flight
        mdif.inValid = 1; mdif.inOpcode = OPC_MULT; mdif.inError = 1;
        irq_ack = 0; clr = 0;
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b1;
      end else begin
        v  = $urandom_range(9) < 7;
        op = ($urandom_range(9) < 8) ? ($urandom_range(1) ? OPC_MULT : OPC_DIV) : 5'($urandom());
        e  = $urandom_range(3) == 0;
        ak = $urandom_range(6) == 0;
        c  = $urandom_range(49) == 0;
        cyc(v, op, $urandom(), 16'($urandom()), $urandom(), $urandom(), e, ak, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multdiv_error_logger.md
MULTDIV_ERROR_LOGGER -- requirements
Module: multdiv_error_logger

Interface
REQ-001 Parameter COUNT_WIDTH, default 16, width of the operation and error counters.
REQ-002 Parameter ERR_THRESHOLD, default 1, number of pending errors that raises outIrq; legal range 1..2^COUNT_WIDTH-1.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 inValid  input  1  operation-complete strobe from the mult/div datapath, one cycle per operation.
REQ-006 inOpcode  input  5  opcode of the completing operation: mult 00110, div 00111.
REQ-007 inA  input  32  operand A, signed.
REQ-008 inB  input  16  operand B, signed.
REQ-009 inMultDivResult  input  32  product or quotient.
REQ-010 inRemainder  input  32  division remainder.
REQ-011 inError  input  1  mod-31 residue checker error output for the same operation.
REQ-012 inIrqAck  input  1  single-cycle acknowledge from the handler.
REQ-013 inClear  input  1  synchronous clear of counters, snapshot and state.
REQ-014 outOpCount  output  COUNT_WIDTH  checked operations since reset or clear, saturating.
REQ-015 outErrorCount  output  COUNT_WIDTH  detected errors since reset or clear, saturating.
REQ-016 outSnapValid  output  1  snapshot registers hold a captured failing operation.
REQ-017 outSnapOpcode/outSnapA/outSnapB/outSnapResult/outSnapRemainder  output  5/32/16/32/32  fields of the first failing operation.
REQ-018 outIrq  output  1  error interrupt, level, held until acknowledged.
REQ-019 outState  output  2  current FSM state encoding, for debug.

Function
REQ-020 opEvent SHALL be inValid AND inOpcode in {00110, 00111}; all other inValid cycles SHALL be ignored, including inError.
REQ-021 errEvent SHALL be opEvent AND inError.
REQ-022 outOpCount SHALL increment by 1 on each opEvent and hold at all-ones once reached (no wrap).
REQ-023 outErrorCount SHALL increment by 1 on each errEvent and saturate at all-ones.
REQ-024 An internal pending counter (COUNT_WIDTH, saturating) SHALL increment on errEvent and clear on acknowledge.
REQ-025 FSM states: IDLE=00, LOGGED=01, ALERT=10; 11 is unreachable and SHALL recover to IDLE.
REQ-026 IDLE: on errEvent, capture snapshot, set outSnapValid, and go to ALERT if ERR_THRESHOLD==1, else go to LOGGED.
REQ-027 LOGGED: go to ALERT in the cycle the pending count, including the current errEvent, reaches ERR_THRESHOLD; snapshot SHALL NOT be overwritten.
REQ-028 ALERT: outIrq=1; on inIrqAck go to IDLE, clear outSnapValid and the pending count; the snapshot data registers hold their values.
REQ-029 inIrqAck outside ALERT SHALL have no effect.
REQ-030 errEvent coincident with inIrqAck in ALERT: the lifetime counters increment, the pending count becomes 1, no capture occurs, and the state is IDLE.
REQ-031 inClear SHALL take priority over all events in the same cycle: counters and pending count to 0, outSnapValid=0, state IDLE, outIrq=0.
REQ-032 All outputs SHALL be registered; effects are visible on the clock edge after the sampling edge (latency 1).
REQ-033 outIrq SHALL be a decode of the registered state (state==ALERT).

Reset
REQ-034 While reset is low: all counters 0, all snapshot fields 0, outSnapValid=0, outIrq=0, state IDLE (outState=00).
REQ-035 Reset asserted mid-operation SHALL discard any in-flight event; after deassertion, the first sampled edge behaves as from IDLE.

Structure
REQ-036 A shared package SHALL hold the opcode constants (OPC_MULT=00110, OPC_DIV=00111) and the state encodings.
REQ-037 One sub-module, sat_counter (parameterised width, inc, clr), SHALL implement each of the three saturating counters.

Verification
REQ-038 Reset, then 3 error-free mult ops -> outOpCount=3, outErrorCount=0, outIrq=0, state 00.
REQ-039 Div with inA=100, inB=7, inMultDivResult=14, inRemainder=2, inError=1 and ERR_THRESHOLD=1 -> next cycle outIrq=1, snapshot equals those values, outSnapValid=1.
REQ-040 ERR_THRESHOLD=3, three error ops, the second with a different inA -> state 01 after the first error, outIrq after the third, snapshot holds the first op.
REQ-041 inValid=1, inOpcode=00000, inError=1 -> all counters unchanged, state 00.
REQ-042 In ALERT, inIrqAck plus errEvent in the same cycle -> outErrorCount+1, state 00, outSnapValid=0; with ERR_THRESHOLD=2, one further errEvent reaches ALERT.
REQ-043 COUNT_WIDTH=4 with 20 ops -> outOpCount holds 15; inClear asserted alongside errEvent -> all counts 0, outIrq=0.
